// File: rtl/scrambler.sv
// -----------------------------------------------------------------------------
// scrambler
//
// Frame-synchronous 802.11a/g data scrambler (x^7 + x^4 + 1) placed directly
// upstream of the convolutional encoder. Each accepted WIDTH-bit beat is XORed
// with the scrambler sequence, bit 0 first in time. The result is handed on
// through a single output register on the same AXI-Stream format. The rate
// code (tuser) and the frame delimiter (tlast) ride along with the data
// unchanged.
//
// Ports:
//   aclk           clock
//   areset         synchronous reset, active-high
//   seed[6:0]      scrambler initial state, sampled on the first beat of a frame
//   s_axis_tdata   unscrambled data beat (WIDTH bits)
//   s_axis_tuser   4-bit rate code
//   s_axis_tvalid  upstream valid
//   s_axis_tready  ready to accept a beat
//   s_axis_tlast   last beat of frame
//   m_axis_tdata   scrambled data beat (WIDTH bits)
//   m_axis_tuser   rate code aligned with m_axis_tdata
//   m_axis_tvalid  output valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   last beat, aligned with m_axis_tdata
//
// Build option:
//   SCRAMBLER_SEED_GEN_EN - when defined, the seed port is ignored. An internal
//   seed counter supplies the frame seed instead: it starts at 7'h01 and steps
//   once per completed frame, wrapping 7'h7F -> 7'h01.
// -----------------------------------------------------------------------------
module scrambler #(
  parameter int WIDTH = 24
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [6:0]       seed,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]       s_axis_tuser,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [3:0]       m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
);

  typedef enum logic {
    IDLE,
    RUN
  } fsm_t;

  fsm_t             fsm;
  logic [6:0]       st_q;
  logic [6:0]       frame_seed;
  logic [6:0]       work_st;
  logic [6:0]       st;
  logic             fb;
  logic [6:0]       end_st;
  logic [WIDTH-1:0] scr_data;
  logic             s_hs;

`ifdef SCRAMBLER_SEED_GEN_EN
  logic [6:0] seed_cnt;
  logic       unused_seed;

  assign unused_seed = ^seed;
  assign frame_seed  = seed_cnt;

  // Seed counter advances once per completed frame and skips zero on wrap
  always_ff @(posedge aclk) begin
    if (areset) begin
      seed_cnt <= 7'h01;
    end else if (s_hs && s_axis_tlast) begin
      seed_cnt <= (seed_cnt == 7'h7F) ? 7'h01 : seed_cnt + 7'h01;
    end
  end
`else
  assign frame_seed = seed;
`endif

  // Single output register: a new beat fits whenever the register is empty
  // or is being drained in the same cycle.
  assign s_axis_tready = ~areset & (~m_axis_tvalid | m_axis_tready);
  assign s_hs          = s_axis_tvalid & s_axis_tready;

  // Whole beat scrambled in one cycle. The first beat of a frame starts from
  // the seed, with an all-zero seed replaced by all ones so that the LFSR
  // cannot lock up. Later beats continue from the stored end state.
  always_comb begin
    if (fsm == IDLE) begin
      work_st = (frame_seed == 7'h00) ? 7'h7F : frame_seed;
    end else begin
      work_st = st_q;
    end
    st       = work_st;
    fb       = 1'b0;
    scr_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fb          = st[6] ^ st[3];
      scr_data[i] = s_axis_tdata[i] ^ fb;
      st          = {st[5:0], fb};
    end
    end_st = st;
  end

  // Output register, LFSR state and frame tracking. The register only loads
  // on an accepted beat. Otherwise it either holds or empties after the
  // downstream takes it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 4'h0;
      m_axis_tlast  <= 1'b0;
      st_q          <= 7'h00;
      fsm           <= IDLE;
    end else begin
      if (s_hs) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= scr_data;
        m_axis_tuser  <= s_axis_tuser;
        m_axis_tlast  <= s_axis_tlast;
        st_q          <= end_st;
        fsm           <= s_axis_tlast ? IDLE : RUN;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scrambler.sv
// -----------------------------------------------------------------------------
// tb_scrambler
//
// Self-checking bench for scrambler. Inputs are driven 1 ns after each rising
// edge. The compare process watches every falling edge. It keeps a sequence
// model of the scrambler: the 127-bit sequence is generated from the
// recurrence h[n] = h[n-7] ^ h[n-4], and each frame's bit position is tracked.
// A queue holds the beats that are expected next on the output.
// Define SCRAMBLER_SEED_GEN_EN for both files to exercise the seed counter.
// -----------------------------------------------------------------------------
module tb_scrambler;

  localparam int W = 24;

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   u;
    logic         l;
  } beat_t;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [6:0]   seed = 7'h00;
  logic [W-1:0] s_axis_tdata = '0;
  logic [3:0]   s_axis_tuser = 4'h0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [W-1:0] m_axis_tdata;
  logic [3:0]   m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;

  int tests = 0;
  int failed = 0;
  int readyMode = 0;

  beat_t expQ[$];
  beat_t logQ[$];

  scrambler #(.WIDTH(W)) dut (
    .aclk(aclk),
    .areset(areset),
    .seed(seed),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  // Sequence bits 0..126 for a given initial state: st[k] holds the bit from
  // time -(k+1), so the seed fills h[-7..-1] with st[6] as the oldest bit.
  function automatic logic [126:0] genSeq(input logic [6:0] sd);
    logic [133:0] h;
    logic [126:0] sq;
    for (int j = 0; j < 7; j++) h[j] = sd[6-j];
    for (int n = 0; n < 127; n++) begin
      h[n+7] = h[n] ^ h[n+3];
      sq[n]  = h[n+7];
    end
    return sq;
  endfunction

  function automatic logic [W-1:0] scr(input logic [W-1:0] d, input logic [126:0] sq, input int pos);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[i] ^ sq[(pos + i) % 127];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one beat and waits (bounded) until it is accepted
  task automatic applyStimulus(input logic [W-1:0] d, input logic [3:0] u, input logic l, input logic [6:0] sd);
    int k = 0;
    bit done = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    seed          = sd;
    s_axis_tvalid = 1'b1;
    while (!done && k < 200) begin
      @(negedge aclk);
      done = s_axis_tready;
      @(posedge aclk);
      #1;
      k++;
    end
    if (!done) checkOutput("accept timeout", 64'(k), 64'd0);
    s_axis_tvalid = 1'b0;
    seed          = 7'($urandom);
  endtask

  task automatic waitLog(input int n);
    int k = 0;
    while (logQ.size() < n && k < 300) begin
      @(posedge aclk);
      k++;
    end
    #1;
    if (logQ.size() < n) checkOutput("output timeout", 64'(logQ.size()), 64'(n));
  endtask

  task automatic pulseReset();
    @(posedge aclk);
    #1 areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    checkOutput("tvalid after reset", 64'(m_axis_tvalid), 64'd0);
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = random, 2 = stalled
  always @(posedge aclk) begin
    #1;
    case (readyMode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 3) != 0);
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Compare process: judges the edge just past, then predicts the next edge
  logic         prevAreset = 1'b0;
  logic         prevStall = 1'b0;
  beat_t        prevOut;
  logic         inFrame = 1'b0;
  int           modelPos = 0;
  logic [126:0] modelSeq;
  logic [6:0]   genCnt = 7'h01;

  always @(negedge aclk) begin
    beat_t e;
    beat_t o;
    logic [6:0] sd;
    o.d = m_axis_tdata;
    o.u = m_axis_tuser;
    o.l = m_axis_tlast;
    if (prevAreset) begin
      checkOutput("reset outputs", {35'd0, m_axis_tvalid, m_axis_tdata, m_axis_tuser},
                  64'd0);
      checkOutput("reset tlast", 64'(m_axis_tlast), 64'd0);
    end else begin
      if (prevStall)
        checkOutput("stall hold", {35'd0, o.d, o.u, o.l}, {35'd0, prevOut.d, prevOut.u, prevOut.l});
      checkOutput("tvalid vs pending", 64'(m_axis_tvalid), 64'(expQ.size() != 0));
    end
    if (areset) begin
      checkOutput("tready in reset", 64'(s_axis_tready), 64'd0);
      expQ.delete();
      inFrame = 1'b0;
      genCnt  = 7'h01;
    end else begin
      checkOutput("tready", 64'(s_axis_tready), 64'(!m_axis_tvalid || m_axis_tready));
      if (m_axis_tvalid && m_axis_tready && expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("beat", {35'd0, o.d, o.u, o.l}, {35'd0, e.d, e.u, e.l});
        logQ.push_back(o);
      end
      if (s_axis_tvalid && s_axis_tready) begin
        if (!inFrame) begin
`ifdef SCRAMBLER_SEED_GEN_EN
          sd = genCnt;
`else
          sd = seed;
`endif
          if (sd == 7'h00) sd = 7'h7F;
          modelSeq = genSeq(sd);
          modelPos = 0;
        end
        e.d = scr(s_axis_tdata, modelSeq, modelPos);
        e.u = s_axis_tuser;
        e.l = s_axis_tlast;
        expQ.push_back(e);
        modelPos = (modelPos + W) % 127;
        inFrame  = !s_axis_tlast;
        if (s_axis_tlast) genCnt = (genCnt == 7'h7F) ? 7'h01 : genCnt + 7'h01;
      end
    end
    prevAreset = areset;
    prevStall  = m_axis_tvalid && !m_axis_tready && !areset;
    prevOut    = o;
  end

  initial begin
    logic [143:0] bits;
    logic [5:0]   lasts;
    logic [W-1:0] stallData[5];
    beat_t        refRun[$];
    int           len;
    logic [6:0]   fs;

    // Model pins: known start of the all-ones sequence
    checkOutput("model beat0", 64'(scr('0, genSeq(7'h7F), 0)), 64'h934F70);
    checkOutput("model beat1", 64'(scr('0, genSeq(7'h7F), 24)), 64'h746440);
    checkOutput("model period", 64'(genSeq(7'h7F)), 64'(genSeq(7'h7F) >> 0));

    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    readyMode = 0;
    repeat (2) @(posedge aclk);
    #1;

`ifndef SCRAMBLER_SEED_GEN_EN
    // Single-beat frame from the all-ones seed
    logQ.delete();
    applyStimulus('0, 4'hB, 1'b1, 7'h7F);
    waitLog(1);
    if (logQ.size() >= 1) begin
      checkOutput("single data", 64'(logQ[0].d), 64'h934F70);
      checkOutput("single tuser", 64'(logQ[0].u), 64'hB);
      checkOutput("single tlast", 64'(logQ[0].l), 64'd1);
    end

    // Six zero beats: 144 bits wrap the 127-bit period
    logQ.delete();
    for (int b = 0; b < 6; b++) applyStimulus('0, 4'h3, b == 5, (b == 0) ? 7'h7F : 7'($urandom));
    waitLog(6);
    if (logQ.size() >= 6) begin
      for (int b = 0; b < 6; b++) begin
        bits[b*W +: W] = logQ[b].d;
        lasts[b]       = logQ[b].l;
      end
      checkOutput("period wrap", 64'(bits[143:127]), 64'(bits[16:0]));
      checkOutput("period tlast", 64'(lasts), 64'h20);
    end

    // Back-to-back frames, second with a zero seed
    logQ.delete();
    applyStimulus(24'h123456, 4'h1, 1'b0, 7'h7F);
    applyStimulus(24'hABCDEF, 4'h1, 1'b1, 7'h11);
    applyStimulus('0, 4'h2, 1'b1, 7'h00);
    waitLog(3);
    if (logQ.size() >= 3) checkOutput("zero seed", 64'(logQ[2].d), 64'h934F70);
`endif

    // Mid-frame stall against an unstalled run of the same frame
    for (int b = 0; b < 5; b++) stallData[b] = W'($urandom);
    logQ.delete();
    for (int b = 0; b < 5; b++) applyStimulus(stallData[b], 4'h5, b == 4, 7'h7F);
    waitLog(5);
    refRun = logQ;
    logQ.delete();
    fork
      begin
        for (int b = 0; b < 5; b++) applyStimulus(stallData[b], 4'h5, b == 4, 7'h7F);
      end
      begin
        waitLog(2);
        readyMode = 2;
        repeat (3) @(posedge aclk);
        #1 readyMode = 0;
      end
    join
    waitLog(5);
`ifndef SCRAMBLER_SEED_GEN_EN
    for (int b = 0; b < 5 && b < logQ.size() && b < refRun.size(); b++)
      checkOutput($sformatf("stall vs ref %0d", b), 64'(logQ[b].d), 64'(refRun[b].d));
`endif

    // Reset in the middle of a frame, then a fresh frame
    readyMode = 2;
    applyStimulus(24'h00FF00, 4'h7, 1'b0, 7'h7F);
    repeat (2) @(posedge aclk);
    pulseReset();
    readyMode = 0;
    @(posedge aclk);
    #1 logQ.delete();
    applyStimulus('0, 4'h7, 1'b1, 7'h7F);
    waitLog(1);
`ifndef SCRAMBLER_SEED_GEN_EN
    if (logQ.size() >= 1) checkOutput("post-reset data", 64'(logQ[0].d), 64'h934F70);
`endif

`ifdef SCRAMBLER_SEED_GEN_EN
    // Two zero frames after reset use counter seeds 1 and 2, whatever the port says
    pulseReset();
    @(posedge aclk);
    #1 logQ.delete();
    applyStimulus('0, 4'h1, 1'b1, 7'h7F);
    applyStimulus('0, 4'h1, 1'b1, 7'h00);
    waitLog(2);
    if (logQ.size() >= 2) begin
      checkOutput("gen seed 1", 64'(logQ[0].d), 64'(scr('0, genSeq(7'h01), 0)));
      checkOutput("gen seed 2", 64'(logQ[1].d), 64'(scr('0, genSeq(7'h02), 0)));
    end
`endif

    // Random frames, random gaps and random downstream ready
    readyMode = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 7);
      fs  = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom);
      for (int b = 0; b < len; b++) begin
        applyStimulus(W'($urandom), 4'($urandom), b == len - 1, (b == 0) ? fs : 7'($urandom));
        repeat ($urandom_range(0, 2)) @(posedge aclk);
        #1;
      end
    end

    readyMode = 0;
    for (int k = 0; k < 50 && expQ.size() != 0; k++) @(posedge aclk);
    @(negedge aclk);
    checkOutput("drain", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/scrambler.md
Name: scrambler

Overview:
- Frame-synchronous 802.11a/g data scrambler using x^7 + x^4 + 1.
- Sits directly upstream of the convolutional encoder. It consumes WIDTH-bit DATA-field beats carrying a 4-bit rate code, XORs them with the scrambler sequence, and hands the result to the encoder over the same AXI-Stream format.
- Rate code (tuser) and frame delimiter (tlast) pass through aligned with data.

Parameters:
- WIDTH, 24, data bits per beat. Bit 0 is earliest in time; bit WIDTH-1 is latest. Same ordering the encoder consumes.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- seed  in  7  scrambler initial state, sampled on the first beat of each frame
- s_axis_tdata  in  WIDTH  unscrambled data
- s_axis_tuser  in  4  rate code, passed through
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  ready to accept a beat
- s_axis_tlast  in  1  last beat of frame
- m_axis_tdata  out  WIDTH  scrambled data
- m_axis_tuser  out  4  rate code aligned with m_axis_tdata
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat, aligned with m_axis_tdata

Behaviour:
- Reset (areset=1 at posedge):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
  - state register = 0; FSM = IDLE.
  - Reset mid-frame abandons the frame. No partial beat is emitted after reset.
- Handshakes:
  - s_hs = s_axis_tvalid & s_axis_tready; m_hs = m_axis_tvalid & m_axis_tready.
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready (single output register, full throughput).
  - s_axis_tready is 0 while areset=1.
- Latency: one cycle. A beat accepted at edge N is presented on m_axis_* after edge N.
  - Output register loads on s_hs.
  - m_axis_tvalid clears on m_hs without s_hs.
  - Simultaneous m_hs and s_hs: tvalid stays 1 and the register takes the new beat.
  - Output is held stable while m_axis_tvalid & ~m_axis_tready.
- Scrambler state st[6:0] (st[6]=x7, st[3]=x4). Per bit i=0..WIDTH-1 in time order:
  - fb = st[6]^st[3]
  - out[i] = in[i]^fb
  - st = {st[5:0], fb}
  - Fully unrolled combinationally across WIDTH bits per beat.
- FSM:
  - IDLE:
    - Working state = seed; a seed of 7'h00 is substituted with 7'h7F (avoids lock-up).
    - On s_hs: scramble with the working state, store the end state. Go to RUN, or stay in IDLE if s_axis_tlast=1 (single-beat frame).
  - RUN:
    - Working state = stored state.
    - On s_hs: scramble and store the end state.
    - If s_axis_tlast=1, go to IDLE.
  - No s_hs: state and FSM hold.
- Sequence period is 127 bits. Wrap-around is inherent; no special handling.
- seed is don't-care except in the cycle of the first-beat s_hs.
- tuser and tlast are registered alongside tdata and never modified.

Optional Feature:
- Macro: SCRAMBLER_SEED_GEN_EN.
- Defined:
  - seed port is ignored.
  - Internal 7-bit seed counter is used as the frame seed. It resets to 7'h01.
  - The counter increments on each frame-ending s_hs (tlast=1), wrapping 7'h7F -> 7'h01 and never reaching 0.
- Undefined:
  - seed port is used as described above.
  - No counter logic is present.

Test Plan:
- Seed 7'h7F, one beat tdata=0, tlast=1, tuser=4'hB, m_axis_tready=1 -> m_axis_tdata=24'h934F70, m_axis_tuser=4'hB, m_axis_tlast=1, one cycle after accept; FSM back to IDLE.
- Seed 7'h7F, six zero beats (144 bits), tlast on the 6th -> output bits 127..143 repeat bits 0..16 (period 127); tlast only on the 6th output beat.
- Back-to-back frames with seed 7'h7F then 7'h00 -> second frame's first beat is again 24'h934F70 (zero-seed substitution; state reloaded after tlast).
- m_axis_tready held 0 for 3 cycles mid-frame with s_axis_tvalid=1 -> s_axis_tready=0, m_axis_* stable, no beat lost or duplicated; output stream equals the no-stall run bit-for-bit.
- areset pulsed in RUN mid-frame, then new frame with seed 7'h7F -> m_axis_tvalid=0 the cycle after reset; first new output is 24'h934F70.
- With SCRAMBLER_SEED_GEN_EN: first frame of zeros uses seed 7'h01, second uses 7'h02 -> outputs match a reference model with those seeds, independent of the seed port value.
